// File: rtl/horner_poly_sequencer_pkg.sv
// Shared definitions for the Horner polynomial sequencer and later
// function-approximation sequencers built on FixedPointALU.
//   - ALU opcode constants
//   - sequencer state enum
//   - default Q/N word format and the fixed-point ONE constant
package horner_poly_sequencer_pkg;

    localparam int unsigned Q_DEFAULT = 12;
    localparam int unsigned N_DEFAULT = 32;

    // 1.0 in the default Q format.
    localparam logic [N_DEFAULT-1:0] ONE = N_DEFAULT'(1) << Q_DEFAULT;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_MUL = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StMul,
        StAdd,
        StDone
    } state_e;

endpackage

// File: rtl/horner_poly_sequencer_alu.sv
// FixedPointALU: combinational Q-format two's-complement ALU.
// Ports:
//   a_i, b_i  in  N  operands
//   op_i      in  2  ALU_ADD / ALU_SUB / ALU_MUL (other codes give 0)
//   y_o       out N  result
// Add/sub wrap mod 2^N. Multiply is sign-magnitude: the magnitude product is
// truncated to Q fractional bits and anything above bit N-2 is dropped.
// A result of 0x80..0 is forced to 0. No saturation, no flags.
module FixedPointALU
    import horner_poly_sequencer_pkg::*;
#(
    parameter int unsigned Q = Q_DEFAULT,
    parameter int unsigned N = N_DEFAULT
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic [1:0]   op_i,
    output logic [N-1:0] y_o
);

    logic             sign_a;
    logic             sign_b;
    logic [N-1:0]     mag_a;
    logic [N-1:0]     mag_b;
    logic [2*N-1:0]   prod;
    logic [2*N-1:0]   prod_shr;
    logic [N-1:0]     mul_mag;
    logic [N-1:0]     mul_res;
    logic [N-1:0]     raw;
    logic             unused_prod;

    always_comb begin
        sign_a   = a_i[N-1];
        sign_b   = b_i[N-1];
        mag_a    = sign_a ? (~a_i + 1'b1) : a_i;
        mag_b    = sign_b ? (~b_i + 1'b1) : b_i;
        prod     = {{N{1'b0}}, mag_a} * {{N{1'b0}}, mag_b};
        prod_shr = prod >> Q;
        // Keep only N-1 magnitude bits; the sign is reapplied below.
        mul_mag  = {1'b0, prod_shr[N-2:0]};
        mul_res  = (sign_a ^ sign_b) ? (~mul_mag + 1'b1) : mul_mag;

        case (op_i)
            ALU_ADD: raw = a_i + b_i;
            ALU_SUB: raw = a_i - b_i;
            ALU_MUL: raw = mul_res;
            default: raw = '0;
        endcase

        y_o = (raw == {1'b1, {(N-1){1'b0}}}) ? '0 : raw;
    end

    assign unused_prod = ^prod_shr[2*N-1:N-1];

endmodule

// File: rtl/horner_poly_sequencer.sv
// horner_poly_sequencer: evaluates y = c0 + x*(c1 + x*(c2 + ...)) by Horner's
// rule on a single shared FixedPointALU, one ALU operation per cycle.
// Ports:
//   clk         in  1      clock, rising edge
//   rst         in  1      synchronous active-high reset
//   coef_we     in  1      coefficient write strobe (dropped while busy)
//   coef_addr   in  DEG_W  coefficient index k
//   coef_wdata  in  N      coefficient value c_k
//   start       in  1      start evaluation (ignored while busy)
//   x           in  N      evaluation point, sampled on accepted start
//   degree      in  DEG_W  polynomial degree, sampled on accepted start
//   busy        out 1      evaluation in progress
//   done        out 1      one-cycle pulse, y valid
//   y           out N      result, held until the next done
module horner_poly_sequencer
    import horner_poly_sequencer_pkg::*;
#(
    parameter int unsigned Q     = Q_DEFAULT,
    parameter int unsigned N     = N_DEFAULT,
    parameter int unsigned DEG_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             coef_we,
    input  logic [DEG_W-1:0] coef_addr,
    input  logic [N-1:0]     coef_wdata,
    input  logic             start,
    input  logic [N-1:0]     x,
    input  logic [DEG_W-1:0] degree,
    output logic             busy,
    output logic             done,
    output logic [N-1:0]     y
);

    localparam int unsigned NumCoef = 1 << DEG_W;

    state_e           state_q, state_d;
    logic [N-1:0]     acc_q, acc_d;
    logic [N-1:0]     xr_q, xr_d;
    logic [N-1:0]     y_q, y_d;
    logic [DEG_W-1:0] idx_q, idx_d;
    logic [N-1:0]     coef_q [NumCoef];

    logic [DEG_W-1:0] rd_addr;
    logic [N-1:0]     rd_data;
    logic [N-1:0]     alu_a;
    logic [N-1:0]     alu_b;
    logic [1:0]       alu_op;
    logic [N-1:0]     alu_y;

    FixedPointALU #(
        .Q (Q),
        .N (N)
    ) u_alu (
        .a_i  (alu_a),
        .b_i  (alu_b),
        .op_i (alu_op),
        .y_o  (alu_y)
    );

    assign busy    = (state_q == StLoad) || (state_q == StMul) || (state_q == StAdd);
    assign done    = (state_q == StDone);
    assign y       = y_q;
    assign rd_data = coef_q[rd_addr];

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        xr_d    = xr_q;
        idx_d   = idx_q;
        rd_addr = idx_q;
        // Idle-time ALU inputs held steady to limit toggling.
        alu_a   = acc_q;
        alu_b   = xr_q;
        alu_op  = ALU_ADD;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    xr_d    = x;
                    idx_d   = degree;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                acc_d   = rd_data;
                state_d = (idx_q == '0) ? StDone : StMul;
            end
            StMul: begin
                alu_op  = ALU_MUL;
                acc_d   = alu_y;
                state_d = StAdd;
            end
            StAdd: begin
                rd_addr = idx_q - 1'b1;
                alu_b   = rd_data;
                alu_op  = ALU_ADD;
                acc_d   = alu_y;
                idx_d   = idx_q - 1'b1;
                state_d = (idx_q == DEG_W'(1)) ? StDone : StMul;
            end
            StDone: begin
                // A start here is accepted back-to-back.
                if (start) begin
                    xr_d    = x;
                    idx_d   = degree;
                    state_d = StLoad;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Result is captured on entry to DONE.
        y_d = (state_d == StDone) ? acc_d : y_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            acc_q   <= '0;
            xr_q    <= '0;
            y_q     <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            xr_q    <= xr_d;
            y_q     <= y_d;
            idx_q   <= idx_d;
        end
    end

    // Writes land even when start is accepted the same cycle, so LOAD sees them.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(NumCoef); k++) begin
                coef_q[k] <= '0;
            end
        end else if (coef_we && !busy) begin
            coef_q[coef_addr] <= coef_wdata;
        end
    end

endmodule

// File: doc/horner_poly_sequencer.md
# horner_poly_sequencer

Fixed-point polynomial evaluator built around one shared `FixedPointALU` instance. It holds up to eight Q-format coefficients in a small register file. On `start` it evaluates y = c0 + x·(c1 + x·(c2 + …)) by Horner's rule, alternating ALU multiply and add steps under a state machine. It is the first sequencer driving the ALU and the template for later function-approximation blocks (sigmoid/exp fits).

## Interface
Parameters:
- `Q`, 12: fractional bits; 1.0 = 0x00001000 for Q=12.
- `N`, 32: word width.
- `DEG_W`, 3: coefficient address width; max degree 2^DEG_W − 1 = 7.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `coef_we`  in  1  coefficient write strobe.
- `coef_addr`  in  DEG_W  coefficient index k (writes c_k).
- `coef_wdata`  in  N  coefficient value, Q-format two's complement.
- `start`  in  1  request evaluation; accepted only when `busy`=0.
- `x`  in  N  evaluation point; sampled on accepted `start`.
- `degree`  in  DEG_W  polynomial degree; sampled on accepted `start`.
- `busy`  out  1  high in LOAD/MUL/ADD.
- `done`  out  1  one-cycle pulse; `y` valid.
- `y`  out  N  result; held until next `done`.

## Operation
- States: IDLE, LOAD, MUL, ADD, DONE.
- IDLE/DONE + `start`: latch x→xr, degree→idx; go to LOAD. DONE without start → IDLE.
- LOAD: acc ← c[idx]. If idx=0 → DONE, else → MUL.
- MUL: ALU a=acc, b=xr, op=2'b10; acc ← ALU out → ADD.
- ADD: ALU a=acc, b=c[idx−1], op=2'b00; acc ← ALU out; idx ← idx−1. If idx−1=0 → DONE, else → MUL.
- DONE: `done`=1, `y`=acc (y registered on entry to DONE).
- In IDLE/LOAD/DONE the ALU inputs are don't-care; keep them stable (a=acc, b=xr, op=00) to limit toggling.
- Arithmetic is entirely the ALU's:
  - Add wraps mod 2^N.
  - Multiply is sign-magnitude: truncates to Q fractional bits and drops overflow above bit N−2.
  - Result 0x80000000 is forced to 0.
  - No saturation and no overflow flag.
- Coefficient writes are accepted only when `busy`=0; writes while busy are dropped.
- `coef_we` and `start` in the same idle cycle: the write lands, and LOAD and later reads see the new value.
- `start` while busy is ignored; no queueing.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `y`=0, acc=0, xr=0, idx=0, all c_k=0.
- `rst` mid-operation aborts the evaluation; no `done` is issued for it.
- Latency: `start` sampled at cycle t; `done` high in cycle t+2+2·degree (degree 0 → t+2; degree 7 → t+16).
- ALU is combinational, so one ALU operation per cycle; no pipelining inside the block.
- Back-to-back: `start` in the DONE cycle is accepted, and LOAD follows the next cycle.
- `busy` falls in the same cycle `done` rises.

## Structure
- Shared package holds:
  - ALU opcode constants ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_MUL=2'b10.
  - the state enum.
  - the Q/N defaults and the ONE = 1<<Q constant, reused by later sequencers.
- One sub-module: a `FixedPointALU` instance with Q and N passed through.
- Coefficient file is flops (2^DEG_W × N), with an async read mux indexed by idx or idx−1.

## Test plan
- Degree 0: c0=0x00003000, start with any x → `done` at t+2, `y`=0x00003000.
- Degree 2: c0=0x1000, c1=0x2000, c2=0x3000, x=0x2000 (2.0) → `done` at t+6, `y`=0x00011000 (17.0).
- Negative x: degree 1, c0=0, c1=0x1000, x=0xFFFFE800 (−1.5) → `y`=0xFFFFE800.
- Busy protection: during the degree-2 case, pulse `start` with x=0 and write c1=0x7000 at t+3 → exactly one `done`, `y`=0x00011000; c1 reads 0x2000 afterwards.
- Reset abort: `rst` at t+3 of a degree-3 run → `busy`=0 the next cycle, no `done`. Then start degree 1 with x=0x5000 → `y`=0 (coefficients cleared).
- Back-to-back: `start` in the DONE cycle with x=0x1000 and the degree-2 coefficients → second `done` exactly 6 cycles later, `y`=0x00006000.
